// File: rtl/speed_meter_avg_pkg.sv
// Shared types and scaling defaults for the averaging wheel-speed meter.
package speed_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_BUSY,
        WAIT_READY
    } state_t;

    // Circumference-to-speed scale, 8.8 fixed point (~73.728).
    localparam logic [15:0] CONST_DEFAULT      = 16'h49BA;
    localparam int          CONST_FRAC_DEFAULT = 8;

endpackage

// File: rtl/speed_meter_avg_if.sv
// Handshake and operand bundle between the speed meter and the shared divider.
interface speed_meter_avg_if #(
    parameter int CNT_W = 16
);

    logic             div_req;
    logic             div_gnt;
    logic             div_start;
    logic [CNT_W-1:0] dividend;
    logic [CNT_W-1:0] divisor;
    logic             div_busy;
    logic             div_ready;
    logic [CNT_W-1:0] div_res;

    modport master (
        output div_req, div_start, dividend, divisor,
        input  div_gnt, div_busy, div_ready, div_res
    );

    modport slave (
        input  div_req, div_start, dividend, divisor,
        output div_gnt, div_busy, div_ready, div_res
    );

endinterface

// File: rtl/speed_meter_avg_period_avg.sv
// Ring buffer of the last AVG_DEPTH periods with a running sum; reports the
// newest sample until the buffer has filled, then the mean.
module period_avg #(
    parameter int CNT_W     = 16,
    parameter int AVG_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [CNT_W-1:0] sample,
    output logic [CNT_W-1:0] avg
);

    localparam int LOG2_D = $clog2(AVG_DEPTH);
    localparam int PTR_W  = (AVG_DEPTH > 1) ? LOG2_D : 1;
    localparam int FILL_W = $clog2(AVG_DEPTH + 1);
    localparam int SUM_W  = CNT_W + LOG2_D;

    logic [CNT_W-1:0]  ring_q [AVG_DEPTH];
    logic [CNT_W-1:0]  ring_d [AVG_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [CNT_W-1:0]  newest_q, newest_d;
    logic              full;

    assign full = (fill_q == FILL_W'(AVG_DEPTH));
    assign avg  = full ? CNT_W'(sum_q >> LOG2_D) : newest_q;

    // Stale ring entries after a clear are harmless: nothing is subtracted
    // from the sum until DEPTH fresh samples have overwritten them.
    always_comb begin
        ring_d   = ring_q;
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        sum_d    = sum_q;
        newest_d = newest_q;
        if (clear) begin
            wr_ptr_d = '0;
            fill_d   = '0;
            sum_d    = '0;
            newest_d = '0;
        end else if (push) begin
            ring_d[wr_ptr_q] = sample;
            sum_d    = sum_q + SUM_W'(sample) - (full ? SUM_W'(ring_q[wr_ptr_q]) : SUM_W'(0));
            wr_ptr_d = (wr_ptr_q == PTR_W'(AVG_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            fill_d   = full ? fill_q : fill_q + 1'b1;
            newest_d = sample;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < AVG_DEPTH; i++) ring_q[i] <= '0;
            wr_ptr_q <= '0;
            fill_q   <= '0;
            sum_q    <= '0;
            newest_q <= '0;
        end else begin
            ring_q   <= ring_d;
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            sum_q    <= sum_d;
            newest_q <= newest_d;
        end
    end

endmodule

// File: rtl/speed_meter_avg.sv
// Wheel-speed meter: measures reed periods, averages them and converts the
// mean period to speed through the shared divider.
module speed_meter_avg
    import speed_pkg::*;
#(
    parameter int               CNT_W      = 16,
    parameter int               SPEED_W    = 12,
    parameter int               CIRC_W     = 8,
    parameter logic [15:0]      CONST      = CONST_DEFAULT,
    parameter int               CONST_FRAC = CONST_FRAC_DEFAULT,
    parameter int               SPEED_MAX  = 99,
    parameter int               AVG_DEPTH  = 4,
    parameter logic [CNT_W-1:0] TIMEOUT    = CNT_W'(16'hFFFF)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               reed,
    input  logic [CIRC_W-1:0]  circ,
    input  logic               start,
    output logic [SPEED_W-1:0] speed,
    output logic               valid,
    output logic               stopped,
    speed_meter_avg_if.master  div
);

    localparam int PROD_W = CIRC_W + 16;

    state_t             state_q, state_d;
    logic               reed_q;
    logic               edge_q, edge_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               stopped_q, stopped_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic               valid_q, valid_d;
    logic               div_req_q, div_req_d;
    logic               div_start_q, div_start_d;
    logic [CNT_W-1:0]   dividend_q, dividend_d;
    logic [CNT_W-1:0]   divisor_q, divisor_d;

    logic               timeout_hit, push, clear;
    logic [CNT_W-1:0]   avg;
    logic [PROD_W-1:0]  prod, scaled;
    logic [CNT_W-1:0]   dividend_calc;

    assign edge_d      = reed & ~reed_q;
    assign timeout_hit = (cnt_q == TIMEOUT);
    assign clear       = timeout_hit;
    // The restart edge after a standstill carries no meaningful period.
    assign push        = edge_q & ~stopped_q & ~timeout_hit;

    assign prod          = PROD_W'(circ) * PROD_W'(CONST);
    assign scaled        = prod >> CONST_FRAC;
    assign dividend_calc = (scaled > PROD_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : scaled[CNT_W-1:0];

    period_avg #(
        .CNT_W     (CNT_W),
        .AVG_DEPTH (AVG_DEPTH)
    ) u_period_avg (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .push   (push),
        .sample (cnt_q),
        .avg    (avg)
    );

    always_comb begin
        cnt_d     = cnt_q;
        stopped_d = stopped_q;
        if (edge_q) begin
            cnt_d     = '0;
            stopped_d = 1'b0;
        end else begin
            if (en && !timeout_hit) cnt_d = cnt_q + 1'b1;
            if (timeout_hit) stopped_d = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        speed_d     = speed_q;
        valid_d     = valid_q;
        div_req_d   = div_req_q;
        div_start_d = 1'b0;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        case (state_q)
            IDLE: if (start) begin
                valid_d = 1'b0;
                if (stopped_q) begin
                    speed_d = '0;
                    valid_d = 1'b1;
                end else if (avg == '0) begin
                    speed_d = SPEED_W'(SPEED_MAX);
                    valid_d = 1'b1;
                end else begin
                    state_d   = REQ;
                    div_req_d = 1'b1;
                end
            end
            REQ: if (div.div_gnt && !div.div_busy) begin
                dividend_d  = dividend_calc;
                divisor_d   = avg;
                div_start_d = 1'b1;
                state_d     = WAIT_BUSY;
            end
            WAIT_BUSY: if (div.div_busy) state_d = WAIT_READY;
            WAIT_READY: if (div.div_ready) begin
                speed_d   = (div.div_res > CNT_W'(SPEED_MAX)) ? SPEED_W'(SPEED_MAX)
                                                              : div.div_res[SPEED_W-1:0];
                valid_d   = 1'b1;
                div_req_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            reed_q      <= 1'b0;
            edge_q      <= 1'b0;
            cnt_q       <= '0;
            stopped_q   <= 1'b1;
            speed_q     <= '0;
            valid_q     <= 1'b0;
            div_req_q   <= 1'b0;
            div_start_q <= 1'b0;
            dividend_q  <= '0;
            divisor_q   <= '0;
        end else begin
            state_q     <= state_d;
            reed_q      <= reed;
            edge_q      <= edge_d;
            cnt_q       <= cnt_d;
            stopped_q   <= stopped_d;
            speed_q     <= speed_d;
            valid_q     <= valid_d;
            div_req_q   <= div_req_d;
            div_start_q <= div_start_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
        end
    end

    assign speed         = speed_q;
    assign valid         = valid_q;
    assign stopped       = stopped_q;
    assign div.div_req   = div_req_q;
    assign div.div_start = div_start_q;
    assign div.dividend  = dividend_q;
    assign div.divisor   = divisor_q;

endmodule

// File: tb/tb_speed_meter_avg.sv
// Directed bench for speed_meter_avg with a simple floor-quotient divider model.
module tb_speed_meter_avg;

    logic        clk;
    logic        rst;
    logic        en;
    logic        reed;
    logic [7:0]  circ;
    logic        start;
    logic [11:0] speed;
    logic        valid;
    logic        stopped;

    int checks = 0;
    int passed = 0;
    int start_cnt = 0;
    int req_cnt = 0;

    // 200 * 0x49BA >> 8
    localparam int DIVIDEND_200 = 14745;

    speed_meter_avg_if #(.CNT_W(16)) div_if ();

    speed_meter_avg dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .reed    (reed),
        .circ    (circ),
        .start   (start),
        .speed   (speed),
        .valid   (valid),
        .stopped (stopped),
        .div     (div_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts cycles in which the launch pulse / request were high.
    always @(posedge clk) begin
        if (div_if.div_start === 1'b1) start_cnt++;
        if (div_if.div_req === 1'b1) req_cnt++;
    end

    task automatic do_reset();
        rst = 1'b0;
        en = 1'b0;
        reed = 1'b0;
        start = 1'b0;
        circ = 8'd200;
        div_if.div_gnt = 1'b0;
        div_if.div_busy = 1'b0;
        div_if.div_ready = 1'b0;
        div_if.div_res = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            en = 1'b1;
            @(negedge clk);
        end
        en = 1'b0;
    endtask

    task automatic reed_pulse();
        reed = 1'b1;
        repeat (2) @(negedge clk);
        reed = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic serve_div(input logic [15:0] q, output bit launched);
        launched = 1'b0;
        for (int i = 0; i < 50 && !launched; i++) begin
            @(negedge clk);
            if (div_if.div_start === 1'b1) launched = 1'b1;
        end
        if (launched) begin
            div_if.div_busy = 1'b1;
            repeat (3) @(negedge clk);
            div_if.div_busy = 1'b0;
            div_if.div_ready = 1'b1;
            div_if.div_res = q;
            @(negedge clk);
            div_if.div_ready = 1'b0;
            div_if.div_res = '0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int req_base;
        do_reset();
        req_base = req_cnt;
        checks++; if (speed !== 12'd0) $display("[TB] FAIL reset_speed: got %0d expected 0", speed); else passed++;
        checks++; if (valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", valid); else passed++;
        checks++; if (stopped !== 1'b1) $display("[TB] FAIL reset_stopped: got %b expected 1", stopped); else passed++;
        checks++; if (div_if.div_req !== 1'b0) $display("[TB] FAIL reset_req: got %b expected 0", div_if.div_req); else passed++;
        checks++; if (div_if.div_start !== 1'b0) $display("[TB] FAIL reset_start: got %b expected 0", div_if.div_start); else passed++;
        checks++; if (div_if.dividend !== 16'd0) $display("[TB] FAIL reset_dividend: got %0d expected 0", div_if.dividend); else passed++;
        checks++; if (div_if.divisor !== 16'd0) $display("[TB] FAIL reset_divisor: got %0d expected 0", div_if.divisor); else passed++;
        pulse_start();
        checks++; if (valid !== 1'b1) $display("[TB] FAIL stopped_valid: got %b expected 1", valid); else passed++;
        checks++; if (speed !== 12'd0) $display("[TB] FAIL stopped_speed: got %0d expected 0", speed); else passed++;
        repeat (3) @(negedge clk);
        checks++; if (req_cnt - req_base !== 0) $display("[TB] FAIL stopped_no_req: got %0d req cycles expected 0", req_cnt - req_base); else passed++;
        checks++; if (stopped !== 1'b1) $display("[TB] FAIL stopped_hold: got %b expected 1", stopped); else passed++;
    endtask

    task automatic test_average();
        bit launched;
        int sbase;
        do_reset();
        div_if.div_gnt = 1'b1;
        reed_pulse();
        repeat (4) begin
            tick_n(1000);
            reed_pulse();
        end
        sbase = start_cnt;
        pulse_start();
        serve_div(16'(DIVIDEND_200 / 1000), launched);
        checks++; if (launched !== 1'b1) $display("[TB] FAIL avg4_launch: got %b expected 1", launched); else passed++;
        checks++; if (div_if.dividend !== 16'd14745) $display("[TB] FAIL avg4_dividend: got %0d expected 14745", div_if.dividend); else passed++;
        checks++; if (div_if.divisor !== 16'd1000) $display("[TB] FAIL avg4_divisor: got %0d expected 1000", div_if.divisor); else passed++;
        checks++; if (speed !== 12'd14) $display("[TB] FAIL avg4_speed: got %0d expected 14", speed); else passed++;
        checks++; if (valid !== 1'b1) $display("[TB] FAIL avg4_valid: got %b expected 1", valid); else passed++;
        checks++; if (start_cnt - sbase !== 1) $display("[TB] FAIL avg4_pulses: got %0d expected 1", start_cnt - sbase); else passed++;
        checks++; if (div_if.div_req !== 1'b0) $display("[TB] FAIL avg4_req_drop: got %b expected 0", div_if.div_req); else passed++;

        // Ring now holds 1000,1000,1000,1400 -> mean 1100.
        tick_n(1400);
        reed_pulse();
        pulse_start();
        serve_div(16'(DIVIDEND_200 / 1100), launched);
        checks++; if (div_if.divisor !== 16'd1100) $display("[TB] FAIL mix_divisor: got %0d expected 1100", div_if.divisor); else passed++;
        checks++; if (speed !== 12'd13) $display("[TB] FAIL mix_speed: got %0d expected 13", speed); else passed++;

        do_reset();
        div_if.div_gnt = 1'b1;
        reed_pulse();
        tick_n(300);
        reed_pulse();
        tick_n(500);
        reed_pulse();
        pulse_start();
        serve_div(16'(DIVIDEND_200 / 500), launched);
        checks++; if (div_if.divisor !== 16'd500) $display("[TB] FAIL partial_divisor: got %0d expected 500", div_if.divisor); else passed++;
        checks++; if (speed !== 12'd29) $display("[TB] FAIL partial_speed: got %0d expected 29", speed); else passed++;
    endtask

    task automatic test_saturation();
        bit launched;
        int sbase;
        int rbase;
        do_reset();
        div_if.div_gnt = 1'b1;
        reed_pulse();
        tick_n(100);
        reed_pulse();
        pulse_start();
        serve_div(16'(DIVIDEND_200 / 100), launched);
        checks++; if (div_if.divisor !== 16'd100) $display("[TB] FAIL sat_divisor: got %0d expected 100", div_if.divisor); else passed++;
        checks++; if (speed !== 12'd99) $display("[TB] FAIL sat_speed: got %0d expected 99", speed); else passed++;

        do_reset();
        div_if.div_gnt = 1'b1;
        reed_pulse();
        reed_pulse();
        sbase = start_cnt;
        rbase = req_cnt;
        pulse_start();
        checks++; if (speed !== 12'd99) $display("[TB] FAIL zero_speed: got %0d expected 99", speed); else passed++;
        checks++; if (valid !== 1'b1) $display("[TB] FAIL zero_valid: got %b expected 1", valid); else passed++;
        repeat (5) @(negedge clk);
        checks++; if (start_cnt - sbase !== 0) $display("[TB] FAIL zero_no_launch: got %0d expected 0", start_cnt - sbase); else passed++;
        checks++; if (req_cnt - rbase !== 0) $display("[TB] FAIL zero_no_req: got %0d expected 0", req_cnt - rbase); else passed++;
    endtask

    task automatic test_grant();
        bit launched;
        int sbase;
        do_reset();
        reed_pulse();
        tick_n(200);
        reed_pulse();
        sbase = start_cnt;
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            start = (i == 5 || i == 12);
            @(negedge clk);
        end
        start = 1'b0;
        checks++; if (div_if.div_req !== 1'b1) $display("[TB] FAIL gnt_req_held: got %b expected 1", div_if.div_req); else passed++;
        checks++; if (start_cnt - sbase !== 0) $display("[TB] FAIL gnt_no_pulse: got %0d expected 0", start_cnt - sbase); else passed++;
        checks++; if (valid !== 1'b0) $display("[TB] FAIL gnt_valid_low: got %b expected 0", valid); else passed++;
        div_if.div_gnt = 1'b1;
        serve_div(16'(DIVIDEND_200 / 200), launched);
        checks++; if (launched !== 1'b1) $display("[TB] FAIL gnt_launch: got %b expected 1", launched); else passed++;
        checks++; if (start_cnt - sbase !== 1) $display("[TB] FAIL gnt_one_pulse: got %0d expected 1", start_cnt - sbase); else passed++;
        checks++; if (speed !== 12'd73) $display("[TB] FAIL gnt_speed: got %0d expected 73", speed); else passed++;
        checks++; if (valid !== 1'b1) $display("[TB] FAIL gnt_valid: got %b expected 1", valid); else passed++;
        checks++; if (div_if.div_req !== 1'b0) $display("[TB] FAIL gnt_req_drop: got %b expected 0", div_if.div_req); else passed++;
    endtask

    task automatic test_timeout();
        bit launched;
        bit seen;
        do_reset();
        div_if.div_gnt = 1'b1;
        reed_pulse();
        tick_n(50);
        reed_pulse();
        tick_n(50);
        reed_pulse();
        tick_n(65534);
        repeat (2) @(negedge clk);
        checks++; if (stopped !== 1'b0) $display("[TB] FAIL timeout_early: got %b expected 0", stopped); else passed++;
        tick_n(1);
        repeat (2) @(negedge clk);
        checks++; if (stopped !== 1'b1) $display("[TB] FAIL timeout_stopped: got %b expected 1", stopped); else passed++;
        reed_pulse();
        checks++; if (stopped !== 1'b0) $display("[TB] FAIL restart_clear: got %b expected 0", stopped); else passed++;
        // Only three stored periods: the old 50s and the restart edge must be gone.
        tick_n(400);
        reed_pulse();
        tick_n(400);
        reed_pulse();
        tick_n(600);
        reed_pulse();
        pulse_start();
        serve_div(16'(DIVIDEND_200 / 600), launched);
        checks++; if (div_if.divisor !== 16'd600) $display("[TB] FAIL restart_divisor: got %0d expected 600", div_if.divisor); else passed++;
        checks++; if (speed !== 12'd24) $display("[TB] FAIL restart_speed: got %0d expected 24", speed); else passed++;

        // Abandon a division sitting in WAIT_READY.
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (div_if.div_start === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b1) $display("[TB] FAIL abort_launch: got %b expected 1", seen); else passed++;
        div_if.div_busy = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (speed !== 12'd0) $display("[TB] FAIL abort_speed: got %0d expected 0", speed); else passed++;
        checks++; if (valid !== 1'b0) $display("[TB] FAIL abort_valid: got %b expected 0", valid); else passed++;
        checks++; if (stopped !== 1'b1) $display("[TB] FAIL abort_stopped: got %b expected 1", stopped); else passed++;
        checks++; if (div_if.div_req !== 1'b0) $display("[TB] FAIL abort_req: got %b expected 0", div_if.div_req); else passed++;
        checks++; if (div_if.dividend !== 16'd0) $display("[TB] FAIL abort_dividend: got %0d expected 0", div_if.dividend); else passed++;
        checks++; if (div_if.divisor !== 16'd0) $display("[TB] FAIL abort_divisor: got %0d expected 0", div_if.divisor); else passed++;
        div_if.div_busy = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        div_if.div_ready = 1'b1;
        div_if.div_res = 16'd5;
        @(negedge clk);
        div_if.div_ready = 1'b0;
        div_if.div_res = '0;
        @(negedge clk);
        checks++; if (valid !== 1'b0) $display("[TB] FAIL abort_ignore_valid: got %b expected 0", valid); else passed++;
        checks++; if (speed !== 12'd0) $display("[TB] FAIL abort_ignore_speed: got %0d expected 0", speed); else passed++;
    endtask

    initial begin
        test_reset();
        test_average();
        test_saturation();
        test_grant();
        test_timeout();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/speed_meter_avg.md
Name: speed_meter_avg

Overview:
Next-generation wheel-speed block for the bike computer. It measures reed-switch periods in time-base ticks and keeps a moving average over AVG_DEPTH revolutions. On request it computes speed = (circ*CONST)/avg_period using the shared divider through a grant/busy/ready handshake. It adds standstill timeout, divide-by-zero and overflow handling over the previous single-period design, and sits between the time base/reed input and the display top-level.

Parameters:
CNT_W, 16, width of period counter, period samples and divider operands
SPEED_W, 12, width of speed output
CIRC_W, 8, width of circumference input
CONST, 16'h49BA, scale factor in fixed point (~73.728)
CONST_FRAC, 8, fractional bits of CONST
SPEED_MAX, 99, saturation value of speed
AVG_DEPTH, 4, averaged periods; power of 2, range 1..16
TIMEOUT, 16'hFFFF, tick count at which the wheel is declared stopped

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
en  in  1  time-base tick, one cycle wide
reed  in  1  synchronised reed level; a rising edge marks a revolution
circ  in  CIRC_W  wheel circumference, sampled at divider launch
start  in  1  one-cycle speed request
speed  out  SPEED_W  last computed speed
valid  out  1  speed is current
stopped  out  1  standstill detected
div_req  out  1  request for the shared divider
div_gnt  in  1  divider granted to this block
div_start  out  1  one-cycle divider launch pulse
dividend  out  CNT_W  divider operand
divisor  out  CNT_W  divider operand
div_busy  in  1  divider working
div_ready  in  1  quotient valid
div_res  in  CNT_W  quotient

Behaviour:
- Reset (rst=0, asynchronous) clears everything: cnt=0, buffer empty (fill=0), speed=0, valid=0, stopped=1, div_req=0, div_start=0, dividend=0, divisor=0, FSM=IDLE.
- Reed edge = reed & ~reed_q, registered.
- Period counter:
  - On an edge, capture cnt into the ring buffer and set cnt=0; an en in the same cycle is dropped.
  - Otherwise en increments cnt, saturating at TIMEOUT.
- Standstill:
  - When cnt reaches TIMEOUT: stopped=1 and fill=0.
  - The first edge while stopped only restarts cnt and clears stopped; no sample is stored.
- Averaging:
  - The ring buffer keeps a running sum (CNT_W+log2 AVG_DEPTH bits).
  - avg = sum>>log2(AVG_DEPTH) once fill==AVG_DEPTH; before that, avg = the newest sample.
- Dividend = (circ*CONST)>>CONST_FRAC, saturated to all-ones of CNT_W.
- FSM:
  - IDLE: on start, clear valid.
    - If stopped: speed=0 and valid=1 in the next cycle; no divider use.
    - Else if avg==0: speed=SPEED_MAX, valid=1.
    - Else go to REQ.
  - REQ: div_req=1; when div_gnt & ~div_busy, register dividend/divisor(avg) and pulse div_start for exactly 1 cycle; go to WAIT_BUSY.
  - WAIT_BUSY: on div_busy=1, go to WAIT_READY.
  - WAIT_READY: on div_ready=1, speed = min(div_res, SPEED_MAX) truncated to SPEED_W, valid=1, div_req=0; go to IDLE.
- div_req stays high from REQ until the result is taken.
- start outside IDLE is ignored; valid stays 0 until the pending result arrives.
- Reed edges during a division update the buffer; operands already latched are unaffected.
- Reset mid-division abandons the transaction; the divider result is ignored.

Decomposition:
- Package speed_pkg holds the FSM state enum (IDLE, REQ, WAIT_BUSY, WAIT_READY) and the CONST/CONST_FRAC defaults.
- One sub-module, period_avg: ring buffer, fill counter, running sum and avg output, with clear and push inputs.

Test Plan:
- Reset, no reed, start → speed=0, valid=1 next cycle, stopped=1, div_req never asserted.
- circ=200, four periods of 1000 ticks, start, divider model with floor quotient → dividend=14745, divisor=1000, speed=14.
- Periods 1000,1000,1000,1400 (AVG_DEPTH=4), start → divisor=1100, speed=13; after 2 periods only, divisor=the latest period.
- Period 100, circ=200 → quotient 147 → speed=99. avg=0 via two edges in consecutive cycles → speed=99, no divider launch.
- Hold div_gnt=0 for 20 cycles → div_req stays 1 and div_start stays 0; grant → exactly one div_start pulse; start pulses in between are ignored.
- en held with no reed for 65535 ticks → stopped=1 and buffer cleared; next edge clears stopped without a sample; assert rst during WAIT_READY → all outputs at reset values immediately.
